motor_status_logger: RTL

//  Samples the 48 motor status lines (pl_pfail, pl_sw_outa, pl_sw_outb, 16 motors each).
//  On any change, writes a timestamped 4-word entry into a dual-port BRAM ring buffer.

---
 rtl/motor_status_logger.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/motor_status_logger.sv
// Purpose: logs timestamped snapshots of 48 motor status lines into a BRAM ring, one 4-word entry per change.
// Latency: an input edge reaches the first write word G_SYNC_STAGES+1 cycles later; each entry takes 4 write cycles.
// Backpressure: none; changes that arrive while an entry is being written are coalesced into one follow-up entry.
module motor_status_logger #(
    parameter int          G_ENTRIES     = 256,
    parameter logic [31:0] G_BASE_ADDR   = 32'h0,
    parameter int          G_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pl_pfail_ib,
    input  logic [15:0] pl_sw_outa_ib,
    input  logic [15:0] pl_sw_outb_ib,
    output logic        buf_en_o,
    output logic [3:0]  buf_we_ob,
    output logic [31:0] buf_addr_ob,
    output logic [31:0] buf_din_ob,
    input  logic [31:0] control_ib,
    output logic [31:0] status_ob
);
    localparam int IW = (G_ENTRIES > 1) ? $clog2(G_ENTRIES) : 1;

    typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} state_t;

    typedef struct packed {
        logic        busy;
        logic        wrapped;
        logic        full;
        logic [12:0] rsvd;
        logic [15:0] wr_index;
    } status_t;

    state_t                           state;
    logic [G_SYNC_STAGES-1:0][47:0]   sync_q;
    logic [47:0]                      cur;
    logic [47:0]                      snapshot;
    logic [31:0]                      ts;
    logic [31:0]                      seq;
    logic [IW-1:0]                    wr_index;
    logic                             full;
    logic                             wrapped;
    logic                             en_q;
    logic                             enable;
    logic                             clear;
    logic                             freeze;
    logic                             trigger;
    logic [31:0]                      entry_base;
    status_t                          status_nxt;
    logic                             ctrl_unused;

    assign enable      = control_ib[0];
    assign clear       = control_ib[1];
    assign freeze      = control_ib[2];
    assign ctrl_unused = ^control_ib[31:3];

    // cur is {pfail, sw_outa, sw_outb} after the synchroniser chain
    assign cur = sync_q[G_SYNC_STAGES-1];

    assign trigger = (state == IDLE) && enable && !clear && !(full && freeze) &&
                     ((cur != snapshot) || (enable && !en_q));

    assign entry_base = G_BASE_ADDR + {{(28-IW){1'b0}}, wr_index, 4'b0000};

    assign status_nxt = '{busy: (state != IDLE), wrapped: wrapped, full: full,
                          rsvd: '0, wr_index: 16'(wr_index)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sync_q      <= '0;
            snapshot    <= '0;
            ts          <= '0;
            seq         <= '0;
            wr_index    <= '0;
            full        <= 1'b0;
            wrapped     <= 1'b0;
            en_q        <= 1'b0;
            buf_en_o    <= 1'b0;
            buf_we_ob   <= '0;
            buf_addr_ob <= '0;
            buf_din_ob  <= '0;
            status_ob   <= '0;
        end else begin
            sync_q    <= {sync_q[G_SYNC_STAGES-2:0], pl_pfail_ib, pl_sw_outa_ib, pl_sw_outb_ib};
            ts        <= ts + 32'd1;
            en_q      <= enable;
            status_ob <= status_nxt;
            if (clear) begin
                // abort any write in progress; re-baseline so only later changes log
                state       <= IDLE;
                buf_en_o    <= 1'b0;
                buf_we_ob   <= '0;
                buf_addr_ob <= '0;
                buf_din_ob  <= '0;
                wr_index    <= '0;
                seq         <= '0;
                full        <= 1'b0;
                wrapped     <= 1'b0;
                snapshot    <= cur;
            end else begin
                case (state)
                    IDLE: begin
                        if (trigger) begin
                            snapshot    <= cur;
                            state       <= W0;
                            buf_en_o    <= 1'b1;
                            buf_we_ob   <= 4'hF;
                            buf_addr_ob <= entry_base;
                            buf_din_ob  <= ts;
                        end
                    end
                    W0: begin
                        state       <= W1;
                        buf_addr_ob <= entry_base + 32'd4;
                        buf_din_ob  <= {16'h0, snapshot[47:32]};
                    end
                    W1: begin
                        state       <= W2;
                        buf_addr_ob <= entry_base + 32'd8;
                        buf_din_ob  <= {snapshot[15:0], snapshot[31:16]};
                    end
                    W2: begin
                        state       <= W3;
                        buf_addr_ob <= entry_base + 32'd12;
                        buf_din_ob  <= seq;
                    end
                    W3: begin
                        state       <= IDLE;
                        buf_en_o    <= 1'b0;
                        buf_we_ob   <= '0;
                        buf_addr_ob <= '0;
                        buf_din_ob  <= '0;
                        seq         <= seq + 32'd1;
                        if (wr_index == IW'(G_ENTRIES - 1)) begin
                            wr_index <= '0;
                            full     <= 1'b1;
                            wrapped  <= 1'b1;
                        end else begin
                            wr_index <= wr_index + IW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
